// File: rtl/jpeg_block_sequencer_if.sv
// rtl/jpeg_block_sequencer_if.sv - block handshake and datapath control bundle for the JPEG sequencer
interface jpeg_block_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic        abort;
   logic        huff_done;
   logic        input_enable;
   logic        dct_enable;
   logic        dct_input_enable;
   logic [7:0]  matrix_row;
   logic        zigzag_input_enable;
   logic        Huffman_start;
   logic        block_done;
   logic        timeout_err;
   logic [15:0] block_count;

   // slave is the sequencer; master is the encoder top / block source
   modport slave (
      input  in_valid, abort, huff_done,
      output in_ready, input_enable, dct_enable, dct_input_enable, matrix_row,
             zigzag_input_enable, Huffman_start, block_done, timeout_err, block_count
   );

   modport master (
      output in_valid, abort, huff_done,
      input  in_ready, input_enable, dct_enable, dct_input_enable, matrix_row,
             zigzag_input_enable, Huffman_start, block_done, timeout_err, block_count
   );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// rtl/jpeg_block_sequencer.sv - one-block-at-a-time control sequencer for the 8x8 JPEG encoder datapath
module jpeg_block_sequencer #(
   parameter int unsigned DCT_LATENCY   = 4,
   parameter int unsigned QUANT_LATENCY = 1,
   parameter int unsigned HUFF_TIMEOUT  = 255
) (
   input  logic                  clock,
   input  logic                  reset_n,
   jpeg_block_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, DCT, DWAIT, CAPT, QUANT, HSTART, HWAIT, DONE
   } state_t;

   localparam logic [15:0] DWAIT_LAST = 16'(DCT_LATENCY - 1);
   localparam logic [15:0] HWAIT_LAST = 16'(HUFF_TIMEOUT - 1);
   localparam logic [2:0]  SUB_LAST   = 3'(QUANT_LATENCY);

   state_t      state, state_next;
   logic [15:0] wait_cnt;
   logic [2:0]  row;
   logic [2:0]  sub;
   logic        timeout_err;
   logic [15:0] block_count;

   logic row_last_cycle;
   logic hwait_expired;

   assign row_last_cycle = (sub == SUB_LAST);
   assign hwait_expired  = (wait_cnt == HWAIT_LAST);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid && !bus.abort) state_next = DCT;
         DCT:     state_next = DWAIT;
         DWAIT:   if (wait_cnt == DWAIT_LAST) state_next = CAPT;
         CAPT:    state_next = QUANT;
         QUANT:   if (row_last_cycle && row == 3'd7) state_next = HSTART;
         HSTART:  state_next = HWAIT;
         HWAIT:   if (bus.huff_done || hwait_expired) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (bus.abort && state != IDLE) state_next = IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         row         <= '0;
         sub         <= '0;
         timeout_err <= 1'b0;
         block_count <= '0;
      end else begin
         state <= state_next;

         // One counter serves both the DCT wait and the Huffman timeout; it restarts on every entry
         if ((state == DWAIT || state == HWAIT) && state_next == state)
            wait_cnt <= wait_cnt + 16'd1;
         else
            wait_cnt <= '0;

         if (state == QUANT && state_next == QUANT) begin
            if (row_last_cycle) begin
               sub <= '0;
               row <= row + 3'd1;
            end else begin
               sub <= sub + 3'd1;
            end
         end else begin
            sub <= '0;
            row <= '0;
         end

         if (state == HWAIT && !bus.abort && !bus.huff_done && hwait_expired)
            timeout_err <= 1'b1;

         if (state == DONE && !bus.abort)
            block_count <= block_count + 16'd1;
      end
   end

   assign bus.in_ready            = (state == IDLE);
   assign bus.input_enable        = bus.in_valid && !bus.abort && (state == IDLE);
   assign bus.dct_enable          = (state == DCT);
   assign bus.dct_input_enable    = (state == CAPT);
   assign bus.matrix_row          = (state == QUANT) ? {5'd0, row} : 8'd0;
   assign bus.zigzag_input_enable = (state == QUANT) && row_last_cycle;
   assign bus.Huffman_start       = (state == HSTART);
   assign bus.block_done          = (state == DONE);
   assign bus.timeout_err         = timeout_err;
   assign bus.block_count         = block_count;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// tb/tb_jpeg_block_sequencer.sv - directed table-driven bench for jpeg_block_sequencer
module tb_jpeg_block_sequencer;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   jpeg_block_sequencer_if bus();

   jpeg_block_sequencer #(
      .DCT_LATENCY(4),
      .QUANT_LATENCY(1),
      .HUFF_TIMEOUT(8)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus.slave)
   );

   int tests = 0;
   int fails = 0;

   // {in_ready, input_enable, dct_enable, dct_input_enable, zigzag_input_enable, Huffman_start, block_done, matrix_row}
   typedef struct {
      int          cyc;
      logic [14:0] exp;
   } vec_t;
   vec_t vec[$];

   function automatic logic [14:0] mk(input logic ir, ie, de, die, zz, hs, bd, input logic [7:0] row);
      return {ir, ie, de, die, zz, hs, bd, row};
   endfunction

   function automatic logic [14:0] obs();
      return {bus.in_ready, bus.input_enable, bus.dct_enable, bus.dct_input_enable,
              bus.zigzag_input_enable, bus.Huffman_start, bus.block_done, bus.matrix_row};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Defaults: accept at 0, huff_done at 30
   task automatic run_nominal(input string tag);
      int vi = 0;
      int zz = 0;
      int ie = 0;
      for (int c = 0; c <= 32; c++) begin
         @(negedge clock);
         bus.in_valid  = (c == 0);
         bus.huff_done = (c == 30);
         #1;
         if (bus.zigzag_input_enable) zz++;
         if (bus.input_enable) ie++;
         if (vi < vec.size() && vec[vi].cyc == c) begin
            check($sformatf("%s_c%0d", tag, c), 32'(obs()), 32'(vec[vi].exp));
            vi++;
         end
      end
      check({tag, "_zz_count"}, zz, 8);
      check({tag, "_ie_count"}, ie, 1);
   endtask

   // HUFF_TIMEOUT=8: HWAIT spans 24..31, DONE with timeout_err at 32
   task automatic run_timeout(input string tag, input bit early);
      int bd = 0;
      for (int c = 0; c <= 33; c++) begin
         @(negedge clock);
         bus.in_valid  = (c == 0);
         bus.huff_done = early && (c >= 10) && (c <= 20);
         #1;
         if (bus.block_done) bd++;
         if (c == 31) check({tag, "_c31_bd_to"}, {bus.block_done, bus.timeout_err}, 2'b00);
         if (c == 32) check({tag, "_c32_bd_to"}, {bus.block_done, bus.timeout_err}, 2'b11);
         if (c == 33) check({tag, "_c33_ready"}, {bus.in_ready, bus.block_done}, 2'b10);
      end
      bus.huff_done = 1'b0;
      check({tag, "_bd_count"}, bd, 1);
   endtask

   initial begin
      int ie_cnt;
      int ie_second;
      int bd;

      vec.push_back('{0,  mk(1, 1, 0, 0, 0, 0, 0, 8'd0)});
      vec.push_back('{1,  mk(0, 0, 1, 0, 0, 0, 0, 8'd0)});
      vec.push_back('{2,  mk(0, 0, 0, 0, 0, 0, 0, 8'd0)});
      vec.push_back('{5,  mk(0, 0, 0, 0, 0, 0, 0, 8'd0)});
      vec.push_back('{6,  mk(0, 0, 0, 1, 0, 0, 0, 8'd0)});
      vec.push_back('{7,  mk(0, 0, 0, 0, 0, 0, 0, 8'd0)});
      vec.push_back('{8,  mk(0, 0, 0, 0, 1, 0, 0, 8'd0)});
      vec.push_back('{9,  mk(0, 0, 0, 0, 0, 0, 0, 8'd1)});
      vec.push_back('{10, mk(0, 0, 0, 0, 1, 0, 0, 8'd1)});
      vec.push_back('{13, mk(0, 0, 0, 0, 0, 0, 0, 8'd3)});
      vec.push_back('{14, mk(0, 0, 0, 0, 1, 0, 0, 8'd3)});
      vec.push_back('{21, mk(0, 0, 0, 0, 0, 0, 0, 8'd7)});
      vec.push_back('{22, mk(0, 0, 0, 0, 1, 0, 0, 8'd7)});
      vec.push_back('{23, mk(0, 0, 0, 0, 0, 1, 0, 8'd0)});
      vec.push_back('{24, mk(0, 0, 0, 0, 0, 0, 0, 8'd0)});
      vec.push_back('{30, mk(0, 0, 0, 0, 0, 0, 0, 8'd0)});
      vec.push_back('{31, mk(0, 0, 0, 0, 0, 0, 1, 8'd0)});
      vec.push_back('{32, mk(1, 0, 0, 0, 0, 0, 0, 8'd0)});

      bus.in_valid  = 1'b0;
      bus.abort     = 1'b0;
      bus.huff_done = 1'b0;

      // Reset state
      #1;
      check("reset_outputs", 32'(obs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 8'd0)));
      check("reset_counters", {bus.timeout_err, bus.block_count}, 17'd0);
      bus.in_valid = 1'b1;
      #1;
      check("reset_ie_follows", bus.input_enable, 1'b1);
      bus.in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;

      run_nominal("nominal");
      check("nominal_count", bus.block_count, 16'd1);

      // Back-to-back with in_valid held high
      ie_cnt = 0;
      ie_second = -1;
      for (int c = 0; c <= 64; c++) begin
         @(negedge clock);
         bus.in_valid  = (c < 64);
         bus.huff_done = (c == 30) || (c == 62);
         #1;
         if (bus.input_enable) begin
            ie_cnt++;
            if (c > 0 && ie_second < 0) ie_second = c;
         end
      end
      check("b2b_ie_count", ie_cnt, 2);
      check("b2b_second_accept", ie_second, 32);
      check("b2b_count", bus.block_count, 16'd3);

      // Timeout, then a normal block keeps the sticky flag
      run_timeout("timeout", 1'b0);
      check("timeout_count", bus.block_count, 16'd4);
      run_nominal("post_timeout");
      check("timeout_sticky", bus.timeout_err, 1'b1);
      check("post_timeout_count", bus.block_count, 16'd5);

      // Abort in IDLE blocks the accept
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.abort    = 1'b1;
      #1;
      check("abort_idle_ie", bus.input_enable, 1'b0);
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.abort    = 1'b0;
      #1;
      check("abort_idle_stay", {bus.in_ready, bus.dct_enable}, 2'b10);

      // Abort during QUANT row 3
      for (int c = 0; c <= 14; c++) begin
         @(negedge clock);
         bus.in_valid = (c == 0);
         bus.abort    = (c == 13);
         #1;
         if (c == 13) check("abort_row3", bus.matrix_row, 8'd3);
         if (c == 14) check("abort_idle_next", 32'(obs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 8'd0)));
      end
      bus.abort = 1'b0;
      bd = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         bus.huff_done = c[0];
         #1;
         if (bus.block_done) bd++;
      end
      bus.huff_done = 1'b0;
      check("abort_no_done", bd, 0);
      check("abort_count", bus.block_count, 16'd5);

      // Asynchronous reset mid-DWAIT
      for (int c = 0; c <= 3; c++) begin
         @(negedge clock);
         bus.in_valid = (c == 0);
         #1;
      end
      #1 reset_n = 1'b0;
      #1;
      check("rst_mid_outputs", 32'(obs()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 8'd0)));
      check("rst_mid_counters", {bus.timeout_err, bus.block_count}, 17'd0);
      @(negedge clock);
      reset_n = 1'b1;
      bd = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         bus.huff_done = 1'b1;
         #1;
         if (bus.block_done) bd++;
      end
      bus.huff_done = 1'b0;
      check("rst_idle_huff_ignored", bd, 0);
      check("rst_idle_ready", bus.in_ready, 1'b1);

      // Early huff_done during QUANT is ignored
      run_timeout("early_huff", 1'b1);
      check("early_count", bus.block_count, 16'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
